key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event.sv | 126 ++++++++++++
 tb/tb_key_event.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// key_event: turns a debounced, active-low key level into press / release /
// long-press / auto-repeat event pulses, plus a held level and press counter.
// Optional feature macro: KEY_EVENT_REPEAT_EN (defined -> auto-repeat in HOLD).
module key_event #(
    parameter int unsigned LONG_CYCLES   = 1500000,
    parameter int unsigned REPEAT_CYCLES = 300000
) (
    input  logic       BJ_CLK,
    input  logic       RESET,
    input  logic       BUTTON_IN,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG,
    output logic       REPEAT,
    output logic       HELD,
    output logic [7:0] PRESS_CNT
);

    typedef enum logic [1:0] {
        IDLE,
        DOWN,
        HOLD
    } state_t;

    localparam logic [21:0] LONG_TC   = 22'(LONG_CYCLES - 1);
    localparam logic [21:0] REPEAT_TC = 22'(REPEAT_CYCLES - 1);

`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    logic        sync1, sync2, sync3;
    logic        press_edge, release_edge;
    state_t      state, state_nxt;
    logic [21:0] timer, timer_nxt;
    logic        press_nxt, release_nxt, long_nxt, repeat_nxt;

    // Two-flop synchroniser plus history flop; all load "released" on reset
    always_ff @(posedge BJ_CLK) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= BUTTON_IN;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign press_edge   = sync3 & ~sync2;
    assign release_edge = ~sync3 & sync2;
    assign HELD         = ~sync3;

    // State, timer, registered event pulses and press counter
    always_ff @(posedge BJ_CLK) begin
        if (RESET) begin
            state     <= IDLE;
            timer     <= '0;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
            LONG      <= 1'b0;
            REPEAT    <= 1'b0;
            PRESS_CNT <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            PRESS   <= press_nxt;
            RELEASE <= release_nxt;
            LONG    <= long_nxt;
            REPEAT  <= repeat_nxt;
            if (press_nxt) begin
                PRESS_CNT <= PRESS_CNT + 8'd1;
            end
        end
    end

    // Next-state and event decode; release is checked first so it wins over
    // a coincident terminal count
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (press_edge) begin
                    state_nxt = DOWN;
                    timer_nxt = '0;
                    press_nxt = 1'b1;
                end
            end
            DOWN: begin
                if (release_edge) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (timer == LONG_TC) begin
                    state_nxt = HOLD;
                    timer_nxt = '0;
                    long_nxt  = 1'b1;
                end else begin
                    timer_nxt = timer + 22'd1;
                end
            end
            HOLD: begin
                if (release_edge) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (REPEAT_EN && (timer == REPEAT_TC)) begin
                    timer_nxt  = '0;
                    repeat_nxt = 1'b1;
                end else if (REPEAT_EN) begin
                    timer_nxt = timer + 22'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed-vector bench for key_event (LONG_CYCLES=8, REPEAT_CYCLES=4).
module tb_key_event;

    logic       BJ_CLK = 1'b0;
    logic       RESET;
    logic       BUTTON_IN;
    logic       PRESS, RELEASE, LONG, REPEAT, HELD;
    logic [7:0] PRESS_CNT;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int n_press, n_rel, n_long, n_rep, n_excl;
    int press_cyc, rel_cyc, long_cyc, first_rep, last_rep;
    int k;

    key_event #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .BJ_CLK   (BJ_CLK),
        .RESET    (RESET),
        .BUTTON_IN(BUTTON_IN),
        .PRESS    (PRESS),
        .RELEASE  (RELEASE),
        .LONG     (LONG),
        .REPEAT   (REPEAT),
        .HELD     (HELD),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 BJ_CLK = ~BJ_CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_excl = 0;
        press_cyc = -1; rel_cyc = -1; long_cyc = -1; first_rep = -1; last_rep = -1;
    endtask

    // One clock; sample outputs 1 time unit after the rising edge
    task automatic tick();
        @(posedge BJ_CLK);
        #1;
        cyc++;
        if (PRESS)   begin n_press++; press_cyc = cyc; end
        if (RELEASE) begin n_rel++;   rel_cyc   = cyc; end
        if (LONG)    begin n_long++;  long_cyc  = cyc; end
        if (REPEAT) begin
            if (n_rep == 0) first_rep = cyc;
            n_rep++;
            last_rep = cyc;
        end
        if ((int'(PRESS) + int'(RELEASE) + int'(LONG) + int'(REPEAT)) > 1) n_excl++;
    endtask

    initial begin
        int excl_total;
        excl_total = 0;
        RESET = 1'b1;
        BUTTON_IN = 1'b1;
        clear_counts();

        // Reset state
        repeat (3) tick();
        check("reset_outs", {PRESS, RELEASE, LONG, REPEAT, HELD}, 0);
        check("reset_cnt", PRESS_CNT, 0);
        RESET = 1'b0;
        tick();
        check("post_reset_outs", {PRESS, RELEASE, LONG, REPEAT, HELD}, 0);
        repeat (2) tick();

        // Short press: low 5 cycles
        clear_counts();
        BUTTON_IN = 1'b0;
        k = cyc + 1;
        repeat (3) tick();
        check("short_held", HELD, 1);
        repeat (2) tick();
        BUTTON_IN = 1'b1;
        repeat (8) tick();
        check("short_press_n", n_press, 1);
        check("short_press_lat", press_cyc - k, 2);
        check("short_rel_n", n_rel, 1);
        check("short_rel_lat", rel_cyc - k, 7);
        check("short_long_n", n_long, 0);
        check("short_cnt", PRESS_CNT, 1);
        check("short_held_end", HELD, 0);
        excl_total += n_excl;

        // Long hold: low 22 cycles
        clear_counts();
        BUTTON_IN = 1'b0;
        k = cyc + 1;
        repeat (22) tick();
        BUTTON_IN = 1'b1;
        repeat (6) tick();
        check("long_press_n", n_press, 1);
        check("long_n", n_long, 1);
        check("long_after_press", long_cyc - press_cyc, 8);
`ifdef KEY_EVENT_REPEAT_EN
        check("rep_n", n_rep, 3);
        check("rep_first", first_rep - long_cyc, 4);
        check("rep_last", last_rep - first_rep, 8);
`else
        check("rep_n", n_rep, 0);
`endif
        check("long_rel_n", n_rel, 1);
        check("long_rel_lat", rel_cyc - k, 24);
        check("long_cnt", PRESS_CNT, 2);
        excl_total += n_excl;

        // Release edge coincides with the LONG terminal count: low 8 cycles
        clear_counts();
        BUTTON_IN = 1'b0;
        k = cyc + 1;
        repeat (8) tick();
        BUTTON_IN = 1'b1;
        repeat (8) tick();
        check("coin_rel_n", n_rel, 1);
        check("coin_rel_lat", rel_cyc - k, 10);
        check("coin_long_n", n_long, 0);
        check("coin_rep_n", n_rep, 0);
        // FSM must be back in IDLE: a new press is accepted
        BUTTON_IN = 1'b0;
        k = cyc + 1;
        repeat (4) tick();
        BUTTON_IN = 1'b1;
        repeat (6) tick();
        check("coin_idle_press", n_press, 2);
        check("coin_idle_lat", press_cyc - k, 2);
        check("coin_cnt", PRESS_CNT, 4);
        excl_total += n_excl;

        // Reset while in HOLD with the key kept low
        clear_counts();
        BUTTON_IN = 1'b0;
        repeat (15) tick();
        check("hold_long_seen", n_long, 1);
        RESET = 1'b1;
        repeat (2) tick();
        check("rst_hold_outs", {PRESS, RELEASE, LONG, REPEAT, HELD}, 0);
        check("rst_hold_cnt", PRESS_CNT, 0);
        excl_total += n_excl;
        clear_counts();
        RESET = 1'b0;
        k = cyc + 1;
        repeat (6) tick();
        check("rst_press_n", n_press, 1);
        check("rst_press_lat", press_cyc - k, 2);
        check("rst_rel_n", n_rel, 0);
        check("rst_cnt", PRESS_CNT, 1);
        check("rst_held", HELD, 1);
        BUTTON_IN = 1'b1;
        repeat (5) tick();
        check("rst_rel_after", n_rel, 1);
        excl_total += n_excl;

        // 256 short presses from a fresh reset: counter wraps to 0
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        repeat (2) tick();
        clear_counts();
        for (int i = 0; i < 256; i++) begin
            BUTTON_IN = 1'b0;
            repeat (3) tick();
            BUTTON_IN = 1'b1;
            repeat (4) tick();
            if (i == 254) check("wrap_cnt_255", PRESS_CNT, 255);
        end
        repeat (3) tick();
        check("wrap_press_n", n_press, 256);
        check("wrap_rel_n", n_rel, 256);
        check("wrap_cnt", PRESS_CNT, 0);
        check("wrap_long_n", n_long, 0);
        excl_total += n_excl;

        check("mutual_excl", excl_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
